// File: rtl/runner_session_controller.sv
`default_nettype none
// ============================================================================
// Module  : runner_session_controller
// Brief   : Session sequencer for the runner-monitor datapath: 1 s tick strobe,
//           accumulator clear, start/pause/stop, emergency alarm, length limit.
//           Optional idle auto-pause enabled by defining RUNNER_AUTO_PAUSE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module runner_session_controller #(
    parameter int CLK_PER_SEC     = 50_000_000,
    parameter int MAX_SESSION_SEC = 255,
    parameter int EMERG_LIMIT     = 3,
    parameter int IDLE_LIMIT      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       stop_btn,
    input  logic [1:0] steps_per_second,
    input  logic [1:0] hr_classification,
    output logic       calc_valid,
    output logic       calc_rst,
    output logic [2:0] state,
    output logic [7:0] session_sec,
    output logic       alarm,
    output logic       session_done
);

    localparam int TICK_W = $clog2(CLK_PER_SEC);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLEAR = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_ALARM = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(CLK_PER_SEC - 1);
    localparam logic [TICK_W-1:0] c_TICK_TERM = TICK_W'(CLK_PER_SEC - 2);
    localparam logic [TICK_W-1:0] c_TICK_ONE  = TICK_W'(1);
    localparam logic [7:0]        c_SEC_MAX   = 8'(MAX_SESSION_SEC);
    localparam logic [3:0]        c_EMERG_LIM = 4'(EMERG_LIMIT);

    logic [2:0]        r_state;
    logic [TICK_W-1:0] r_tick;
    logic [7:0]        r_sec;
    logic [3:0]        r_emerg;
    logic              r_calc_valid;
    logic              r_calc_rst;
    logic              r_alarm;
    logic              r_done;

    logic [2:0]        w_next_state;
    logic [TICK_W-1:0] w_tick_next;
    logic [7:0]        w_sec_next;
    logic [3:0]        w_emerg_next;
    logic              w_fire;

`ifdef RUNNER_AUTO_PAUSE_EN
    localparam logic [3:0] c_IDLE_LIM = 4'(IDLE_LIMIT);
    logic [3:0] r_idle;
    logic       r_auto;
    logic [3:0] w_idle_next;
    logic       w_auto_next;
    logic       w_unused;
    assign w_unused = hr_classification[0];
`else
    logic       w_unused;
    assign w_unused = ^{steps_per_second, hr_classification[0], IDLE_LIMIT[0]};
`endif

    // Terminal decision is taken one cycle early so the registered strobe
    // coincides with tick_cnt == CLK_PER_SEC-1; session end/alarm/auto-pause
    // transitions are taken in that strobe cycle, after the strobe is issued.
    always_comb begin
        w_next_state = r_state;
        w_tick_next  = r_tick;
        w_sec_next   = r_sec;
        w_emerg_next = r_emerg;
        w_fire       = 1'b0;
`ifdef RUNNER_AUTO_PAUSE_EN
        w_idle_next  = r_idle;
        w_auto_next  = r_auto;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (start_btn) w_next_state = c_ST_CLEAR;
            end
            c_ST_CLEAR: begin
                w_next_state = c_ST_RUN;
                w_tick_next  = '0;
                w_sec_next   = 8'd0;
                w_emerg_next = 4'd0;
`ifdef RUNNER_AUTO_PAUSE_EN
                w_idle_next  = 4'd0;
                w_auto_next  = 1'b0;
`endif
            end
            c_ST_RUN: begin
                if (r_tick == c_TICK_LAST) begin
                    w_tick_next = '0;
                    if (stop_btn || (r_sec == c_SEC_MAX)) begin
                        w_next_state = c_ST_DONE;
                    end else if (r_emerg == c_EMERG_LIM) begin
                        w_next_state = c_ST_ALARM;
                    end else if (pause_btn) begin
                        w_next_state = c_ST_PAUSE;
`ifdef RUNNER_AUTO_PAUSE_EN
                    end else if (r_idle == c_IDLE_LIM) begin
                        w_next_state = c_ST_PAUSE;
                        w_auto_next  = 1'b1;
`endif
                    end
                end else if (stop_btn) begin
                    w_next_state = c_ST_DONE;
                end else if (pause_btn) begin
                    w_next_state = c_ST_PAUSE;
                end else begin
                    w_tick_next = r_tick + c_TICK_ONE;
                    if (r_tick == c_TICK_TERM) begin
                        w_fire       = 1'b1;
                        w_sec_next   = r_sec + 8'd1;
                        w_emerg_next = hr_classification[1] ? (r_emerg + 4'd1) : 4'd0;
`ifdef RUNNER_AUTO_PAUSE_EN
                        w_idle_next  = (steps_per_second == 2'd0) ? (r_idle + 4'd1) : 4'd0;
`endif
                    end
                end
            end
            c_ST_PAUSE: begin
                if (stop_btn) begin
                    w_next_state = c_ST_DONE;
                end else if (start_btn || pause_btn) begin
                    w_next_state = c_ST_RUN;
`ifdef RUNNER_AUTO_PAUSE_EN
                    w_idle_next  = 4'd0;
                    w_auto_next  = 1'b0;
                end else if (r_auto && (steps_per_second != 2'd0)) begin
                    w_next_state = c_ST_RUN;
                    w_idle_next  = 4'd0;
                    w_auto_next  = 1'b0;
`endif
                end
            end
            c_ST_ALARM: begin
                if (stop_btn) begin
                    w_next_state = c_ST_DONE;
                end else if (start_btn && !hr_classification[1]) begin
                    w_next_state = c_ST_RUN;
                    w_emerg_next = 4'd0;
                end
            end
            c_ST_DONE: begin
                if (start_btn) w_next_state = c_ST_CLEAR;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_tick       <= '0;
            r_sec        <= 8'd0;
            r_emerg      <= 4'd0;
            r_calc_valid <= 1'b0;
            r_calc_rst   <= 1'b0;
            r_alarm      <= 1'b0;
            r_done       <= 1'b0;
`ifdef RUNNER_AUTO_PAUSE_EN
            r_idle       <= 4'd0;
            r_auto       <= 1'b0;
`endif
        end else begin
            r_state      <= w_next_state;
            r_tick       <= w_tick_next;
            r_sec        <= w_sec_next;
            r_emerg      <= w_emerg_next;
            r_calc_valid <= w_fire;
            r_calc_rst   <= (w_next_state == c_ST_CLEAR);
            r_alarm      <= (w_next_state == c_ST_ALARM);
            r_done       <= (w_next_state == c_ST_DONE) && (r_state != c_ST_DONE);
`ifdef RUNNER_AUTO_PAUSE_EN
            r_idle       <= w_idle_next;
            r_auto       <= w_auto_next;
`endif
        end
    end

    assign calc_valid   = r_calc_valid;
    assign calc_rst     = r_calc_rst;
    assign state        = r_state;
    assign session_sec  = r_sec;
    assign alarm        = r_alarm;
    assign session_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_runner_session_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_runner_session_controller
// Brief   : Directed bench with a strobe scoreboard for runner_session_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_runner_session_controller;

    localparam int CPS  = 4;
    localparam int MAXS = 6;
    localparam int EL   = 3;
    localparam int IL   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       stop_btn  = 1'b0;
    logic [1:0] steps = 2'd1;
    logic [1:0] hr    = 2'd0;
    logic       calc_valid;
    logic       calc_rst;
    logic [2:0] state;
    logic [7:0] session_sec;
    logic       alarm;
    logic       session_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int c;
        int s;
    } exp_t;
    exp_t sb[$];
    exp_t m_e;

    runner_session_controller #(
        .CLK_PER_SEC    (CPS),
        .MAX_SESSION_SEC(MAXS),
        .EMERG_LIMIT    (EL),
        .IDLE_LIMIT     (IL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_btn        (start_btn),
        .pause_btn        (pause_btn),
        .stop_btn         (stop_btn),
        .steps_per_second (steps),
        .hr_classification(hr),
        .calc_valid       (calc_valid),
        .calc_rst         (calc_rst),
        .state            (state),
        .session_sec      (session_sec),
        .alarm            (alarm),
        .session_done     (session_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input int s);
        exp_t e;
        e.c = c;
        e.s = s;
        sb.push_back(e);
    endtask

    // Every strobe must match the next scheduled (cycle, session_sec) entry.
    always @(negedge clk) begin
        if (!rst && calc_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $error("FAIL unexpected_calc_valid: observed strobe at cycle %0d expected none", cyc);
            end else begin
                m_e = sb.pop_front();
                assert (cyc == m_e.c && int'(session_sec) == m_e.s && state == 3'd2) else begin
                    n_errors++;
                    $error("FAIL calc_valid_event: observed cycle %0d sec %0d state %0d expected cycle %0d sec %0d state 2",
                           cyc, session_sec, state, m_e.c, m_e.s);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int c1;
        int c2;
        int c3;
        int c4;

        // Reset state and ignored buttons in IDLE
        step(2);
        chk("rst_state", state, 0);
        chk("rst_outputs", {calc_valid, calc_rst, alarm, session_done}, 0);
        chk("rst_sec", session_sec, 0);
        rst = 1'b0;
        step(1);
        stop_btn = 1'b1; pause_btn = 1'b1;
        step(1);
        stop_btn = 1'b0; pause_btn = 1'b0;
        chk("idle_ignores_stop_pause", state, 0);

        // 1: full session to the length limit
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        c0 = cyc;
        chk("clear_state", state, 1);
        chk("clear_calc_rst", calc_rst, 1);
        for (int k = 1; k <= MAXS; k++) push(c0 + CPS * k, k);
        step(1);
        chk("run_entry_state", state, 2);
        chk("run_calc_rst_pulse", calc_rst, 0);
        chk("run_sec0", session_sec, 0);
        step(23);
        chk("last_strobe", calc_valid, 1);
        step(1);
        chk("done_state", state, 5);
        chk("done_pulse", session_done, 1);
        chk("done_no_strobe", calc_valid, 0);
        step(1);
        chk("done_pulse_end", session_done, 0);
        chk("done_sec_held", session_sec, 6);
        step(8);
        chk("t1_sb_drained", sb.size(), 0);

        // 2: sustained emergency -> ALARM, acknowledge rules
        hr = 2'b10;
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        c1 = cyc;
        for (int k = 1; k <= 3; k++) push(c1 + CPS * k, k);
        step(13);
        chk("alarm_state", state, 4);
        chk("alarm_flag", alarm, 1);
        step(3);
        pause_btn = 1'b1;
        step(1);
        pause_btn = 1'b0;
        chk("alarm_ignores_pause", state, 4);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        chk("alarm_ignores_start_emerg", state, 4);
        hr = 2'b00;
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        c2 = cyc;
        chk("alarm_ack_state", state, 2);
        chk("alarm_ack_flag", alarm, 0);
        push(c2 + 3, 4);

        // 3: pause at tick_cnt=1 preserves the partial second
        step(5);
        pause_btn = 1'b1;
        step(1);
        pause_btn = 1'b0;
        chk("pause_state", state, 3);
        step(10);
        chk("pause_held", state, 3);
        chk("pause_sec_held", session_sec, 4);
        pause_btn = 1'b1;
        step(1);
        pause_btn = 1'b0;
        c3 = cyc;
        chk("resume_state", state, 2);
        push(c3 + 2, 5);

        // 4: stop coincident with the terminal tick suppresses the strobe
        step(5);
        stop_btn = 1'b1;
        step(1);
        stop_btn = 1'b0;
        chk("stop_state", state, 5);
        chk("stop_done_pulse", session_done, 1);
        chk("stop_no_strobe", calc_valid, 0);
        chk("stop_sec_held", session_sec, 5);
        chk("t234_sb_drained", sb.size(), 0);

        // 5: zero cadence for IDLE_LIMIT ticks
        steps = 2'd0;
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        c4 = cyc;
        push(c4 + 4, 1);
        push(c4 + 8, 2);
        step(9);
`ifdef RUNNER_AUTO_PAUSE_EN
        chk("auto_pause_state", state, 3);
        push(c4 + 13, 3);
`else
        chk("no_auto_pause_state", state, 2);
        push(c4 + 12, 3);
`endif
        steps = 2'd1;
        step(1);
        chk("auto_resume_state", state, 2);
        step(4);
        chk("t5_sb_drained", sb.size(), 0);

        // 6: reset mid-RUN
        step(1);
        rst = 1'b1;
        step(1);
        chk("midrun_rst_state", state, 0);
        chk("midrun_rst_sec", session_sec, 0);
        chk("midrun_rst_outputs", {calc_valid, calc_rst, alarm, session_done}, 0);
        rst = 1'b0;
        step(3);
        chk("post_rst_idle", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
